voxel_addr_gen: RTL and testbench
=================================

// Module: voxel_addr_gen
// PURPOSE
//  Pipelined, parametrised voxel-address generator for the traversal datapath.
//  Accepts signed (x,y,z) voxel coordinates, bounds-checks them against a
//  2^X_BITS x 2^Y_BITS x 2^Z_BITS grid, maps them to linear or brick-tiled layout,
//  adds a per-request base address and returns address + OOB flag + tag.
//  Sits between the ray stepper and the voxel memory read port; valid/ready on both sides.
// PARAMETERS
//  X_BITS      5   log2 grid size in X (likewise Y_BITS, Z_BITS, default 5)
//  COORD_W     7   signed input coordinate width; must exceed max(X/Y/Z_BITS)
//  BRICK_BITS  2   log2 brick edge for tiled mode; 1 <= BRICK_BITS <= min(X/Y/Z_BITS)
//  MEM_AW      16  output address width; must be >= X_BITS+Y_BITS+Z_BITS
//  TAG_W       8   opaque tag carried with each request
//  DROP_OOB    0   1: OOB requests are consumed and never emitted; 0: emitted, out_oob=1
//  CNT_W       16  OOB event counter width
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        async active-low reset
//  in_valid       in   1        request valid
//  in_ready       out  1        request accepted when in_valid && in_ready
//  in_x/in_y/in_z in   COORD_W  signed voxel coordinates
//  in_tag         in   TAG_W    request tag
//  cfg_mode       in   1        0 linear, 1 brick; sampled with the request
//  cfg_base       in   MEM_AW   base address; sampled with the request
//  out_valid      out  1        result valid
//  out_ready      in   1        result consumed when out_valid && out_ready
//  out_addr       out  MEM_AW   cfg_base + layout offset (0 when out_oob)
//  out_oob        out  1        coordinate outside grid
//  out_tag        out  TAG_W    tag of the request
//  oob_count      out  CNT_W    saturating count of accepted OOB requests
//  oob_count_clr  in   1        synchronous clear of oob_count
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, pipeline valids=0, oob_count=0;
//    out_addr/out_oob/out_tag=0. in_ready=1 the first cycle after reset.
//  - Two register stages. S1: OOB check, field split, capture mode/base/tag.
//    S2: layout, base add (modulo 2^MEM_AW, carry dropped). Latency 2 cycles
//    accept->out_valid; throughput 1 per cycle with out_ready held high.
//  - Stage advance: s2 loads when !s2_valid || out_ready; s1 loads when !s1_valid ||
//    s2 loads. in_ready = s1 load condition. The combinational out_ready->in_ready path
//    is permitted. No request is dropped, duplicated or reordered under backpressure.
//  - out_* stay stable while out_valid && !out_ready.
//  - OOB: any coord < 0 or >= 2^AXIS_BITS. DROP_OOB=0: emitted with out_oob=1, addr=0.
//    DROP_OOB=1: bubble in S2, nothing emitted, tag discarded.
//  - Linear offset = {z,y,x} (x in LSBs). Brick offset (B=BRICK_BITS) =
//    {z>>B, y>>B, x>>B, z[B-1:0], y[B-1:0], x[B-1:0]}.
//  - cfg_mode/cfg_base changes affect only requests accepted after the change.
//  - oob_count increments by 1 per accepted OOB request (at S1 load), saturates at
//    all-ones. oob_count_clr in the same cycle as an increment: clear wins, result 0.
//  - rst_n asserted mid-stream: all in-flight requests are discarded, none emitted after release.
// STRUCTURE
//  - voxel_pkg: addr_mode_e {ADDR_LINEAR, ADDR_BRICK}, default axis-bit constants,
//    voxel_req_t / voxel_rsp_t structs (coords, tag, mode, base / addr, oob, tag).
//  - One sub-module: voxel_addr_layout (combinational, mode + in-grid coords -> offset).
//  - Elaboration-time assertions on the parameter constraints listed above.
// TESTING
//  1 linear, base 0, (3,2,1) -> out_addr=1091 (0x443), oob=0, exactly 2 cycles after accept.
//  2 brick, B=2, (5,0,0) -> 65; (0,4,0) -> 8<<6=512; same coords linear -> 5 / 128.
//  3 DROP_OOB=0: x=32 then x=-1 -> two outputs oob=1 addr=0, oob_count=2;
//    DROP_OOB=1: same stimulus -> no output, tags absent, oob_count=2.
//  4 10-request stream, out_ready low 5 cycles mid-stream -> in_ready low after 2
//    held, all 10 emitted in order, held outputs stable while stalled.
//  5 MEM_AW=16, cfg_base=0xFFFF, (1,0,0) linear -> out_addr=0x0000 (wrap).
//  6 oob_count forced to all-ones + OOB request -> stays all-ones; clr with OOB same
//    cycle -> 0; rst_n pulse with 2 in flight -> out_valid=0, no output after release.

Source files
------------

// File: rtl/voxel_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : voxel_addr_gen_pkg
//  Description : Shared types and default geometry for the voxel address
//                generator. Holds the address-mode enum, the default axis
//                and bus widths used as parameter defaults, and request /
//                response records sized for the default geometry. These
//                records are used by anything that models the block at its
//                default size.
//  Revision    : 1.0  initial release
// ============================================================================
package voxel_addr_gen_pkg;

    typedef enum logic {
        ADDR_LINEAR = 1'b0,
        ADDR_BRICK  = 1'b1
    } addr_mode_e;

    localparam int C_DEF_AXIS_BITS  = 5;
    localparam int C_DEF_COORD_W    = 7;
    localparam int C_DEF_BRICK_BITS = 2;
    localparam int C_DEF_MEM_AW     = 16;
    localparam int C_DEF_TAG_W      = 8;
    localparam int C_DEF_CNT_W      = 16;

    typedef struct packed {
        logic signed [C_DEF_COORD_W-1:0] x;
        logic signed [C_DEF_COORD_W-1:0] y;
        logic signed [C_DEF_COORD_W-1:0] z;
        logic        [C_DEF_TAG_W-1:0]   tag;
        addr_mode_e                      mode;
        logic        [C_DEF_MEM_AW-1:0]  base;
    } voxel_req_t;

    typedef struct packed {
        logic [C_DEF_MEM_AW-1:0] addr;
        logic                    oob;
        logic [C_DEF_TAG_W-1:0]  tag;
    } voxel_rsp_t;

endpackage : voxel_addr_gen_pkg
`default_nettype wire

// File: rtl/voxel_addr_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : voxel_addr_gen_if
//  Description : Request/response bundle of the voxel address generator.
//                Request side : in_valid/in_ready, in_x/in_y/in_z (signed),
//                               in_tag, cfg_mode, cfg_base.
//                Response side: out_valid/out_ready, out_addr, out_oob,
//                               out_tag.
//                Side band    : oob_count (saturating), oob_count_clr.
//                master = requester (ray stepper side), slave = generator.
//  Revision    : 1.0  initial release
// ============================================================================
interface voxel_addr_gen_if
    import voxel_addr_gen_pkg::*;
#(
    parameter int COORD_W = C_DEF_COORD_W,
    parameter int TAG_W   = C_DEF_TAG_W,
    parameter int MEM_AW  = C_DEF_MEM_AW,
    parameter int CNT_W   = C_DEF_CNT_W
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic signed [COORD_W-1:0] in_x;
    logic signed [COORD_W-1:0] in_y;
    logic signed [COORD_W-1:0] in_z;
    logic        [TAG_W-1:0]   in_tag;
    logic                      cfg_mode;
    logic        [MEM_AW-1:0]  cfg_base;

    logic                      out_valid;
    logic                      out_ready;
    logic        [MEM_AW-1:0]  out_addr;
    logic                      out_oob;
    logic        [TAG_W-1:0]   out_tag;

    logic        [CNT_W-1:0]   oob_count;
    logic                      oob_count_clr;

    modport master (
        output in_valid, in_x, in_y, in_z, in_tag, cfg_mode, cfg_base,
        output out_ready, oob_count_clr,
        input  in_ready, out_valid, out_addr, out_oob, out_tag, oob_count
    );

    modport slave (
        input  in_valid, in_x, in_y, in_z, in_tag, cfg_mode, cfg_base,
        input  out_ready, oob_count_clr,
        output in_ready, out_valid, out_addr, out_oob, out_tag, oob_count
    );

endinterface : voxel_addr_gen_if
`default_nettype wire

// File: rtl/voxel_addr_layout.sv
`default_nettype none
// ============================================================================
//  Module      : voxel_addr_layout
//  Description : Combinational mapping of in-grid voxel coordinates to a
//                linear offset inside the grid.
//                  linear : {z, y, x}, x in the LSBs
//                  brick  : {z>>B, y>>B, x>>B, z[B-1:0], y[B-1:0], x[B-1:0]}
//                Ports: i_mode (layout select), i_x/i_y/i_z (in-grid coords),
//                       o_offset (X_BITS+Y_BITS+Z_BITS wide).
//  Revision    : 1.0  initial release
// ============================================================================
module voxel_addr_layout
    import voxel_addr_gen_pkg::*;
#(
    parameter int X_BITS     = C_DEF_AXIS_BITS,
    parameter int Y_BITS     = C_DEF_AXIS_BITS,
    parameter int Z_BITS     = C_DEF_AXIS_BITS,
    parameter int BRICK_BITS = C_DEF_BRICK_BITS
) (
    input  addr_mode_e                         i_mode,
    input  logic [X_BITS-1:0]                  i_x,
    input  logic [Y_BITS-1:0]                  i_y,
    input  logic [Z_BITS-1:0]                  i_z,
    output logic [X_BITS+Y_BITS+Z_BITS-1:0]    o_offset
);

    localparam int c_off_w = X_BITS + Y_BITS + Z_BITS;
    localparam int c_b     = BRICK_BITS;

    logic [c_off_w-1:0] w_x;
    logic [c_off_w-1:0] w_y;
    logic [c_off_w-1:0] w_z;
    logic [c_off_w-1:0] w_lo_mask;
    logic [c_off_w-1:0] w_linear;
    logic [c_off_w-1:0] w_brick;

    // The brick layout is built from full-width shifted terms rather than
    // concatenated slices so that BRICK_BITS equal to an axis width (an
    // empty brick-index field) needs no special case.
    always_comb begin
        w_x       = c_off_w'(i_x);
        w_y       = c_off_w'(i_y);
        w_z       = c_off_w'(i_z);
        w_lo_mask = (c_off_w'(1) << c_b) - c_off_w'(1);

        w_linear  = (w_z << (X_BITS + Y_BITS)) | (w_y << X_BITS) | w_x;

        w_brick   = ((w_z >> c_b) << (X_BITS + Y_BITS + c_b))
                  | ((w_y >> c_b) << (X_BITS + 2 * c_b))
                  | ((w_x >> c_b) << (3 * c_b))
                  | ((w_z & w_lo_mask) << (2 * c_b))
                  | ((w_y & w_lo_mask) << c_b)
                  |  (w_x & w_lo_mask);

        o_offset  = (i_mode == ADDR_BRICK) ? w_brick : w_linear;
    end

endmodule : voxel_addr_layout
`default_nettype wire

// File: rtl/voxel_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : voxel_addr_gen
//  Description : Two-stage pipelined voxel address generator.
//                Stage 1 bounds-checks the signed coordinates, keeps the
//                in-grid field bits and captures mode/base/tag.
//                Stage 2 applies the layout, adds the base (modulo
//                2^MEM_AW) and presents address/OOB/tag.
//                Ports: clk, rst_n (async assert, active low),
//                       bus (voxel_addr_gen_if.slave: request, response,
//                       oob_count / oob_count_clr).
//  Revision    : 1.0  initial release
// ============================================================================
module voxel_addr_gen
    import voxel_addr_gen_pkg::*;
#(
    parameter int X_BITS     = C_DEF_AXIS_BITS,
    parameter int Y_BITS     = C_DEF_AXIS_BITS,
    parameter int Z_BITS     = C_DEF_AXIS_BITS,
    parameter int COORD_W    = C_DEF_COORD_W,
    parameter int BRICK_BITS = C_DEF_BRICK_BITS,
    parameter int MEM_AW     = C_DEF_MEM_AW,
    parameter int TAG_W      = C_DEF_TAG_W,
    parameter bit DROP_OOB   = 1'b0,
    parameter int CNT_W      = C_DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    voxel_addr_gen_if.slave   bus
);

    localparam int c_off_w = X_BITS + Y_BITS + Z_BITS;

    // ---------------------------------------------------------------------
    // Parameter legality
    // ---------------------------------------------------------------------
    if (COORD_W <= X_BITS || COORD_W <= Y_BITS || COORD_W <= Z_BITS) begin : g_chk_coord_w
        $error("voxel_addr_gen: COORD_W must exceed every axis width");
    end
    if (BRICK_BITS < 1 || BRICK_BITS > X_BITS || BRICK_BITS > Y_BITS ||
        BRICK_BITS > Z_BITS) begin : g_chk_brick_bits
        $error("voxel_addr_gen: BRICK_BITS must lie in 1..min(axis widths)");
    end
    if (MEM_AW < c_off_w) begin : g_chk_mem_aw
        $error("voxel_addr_gen: MEM_AW must hold the full grid offset");
    end

    // ---------------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------------
    logic               r_s1_valid,  w_s1_valid_nxt;
    logic               r_s1_oob,    w_s1_oob_nxt;
    logic [X_BITS-1:0]  r_s1_x,      w_s1_x_nxt;
    logic [Y_BITS-1:0]  r_s1_y,      w_s1_y_nxt;
    logic [Z_BITS-1:0]  r_s1_z,      w_s1_z_nxt;
    addr_mode_e         r_s1_mode,   w_s1_mode_nxt;
    logic [MEM_AW-1:0]  r_s1_base,   w_s1_base_nxt;
    logic [TAG_W-1:0]   r_s1_tag,    w_s1_tag_nxt;

    logic               r_s2_valid,  w_s2_valid_nxt;
    logic               r_s2_oob,    w_s2_oob_nxt;
    logic [MEM_AW-1:0]  r_s2_addr,   w_s2_addr_nxt;
    logic [TAG_W-1:0]   r_s2_tag,    w_s2_tag_nxt;

    logic [CNT_W-1:0]   r_oob_count, w_oob_count_nxt;

    logic               w_s2_load;
    logic               w_s1_load;
    logic               w_accept;
    logic               w_in_oob;
    logic               w_s2_emit;
    logic [c_off_w-1:0] w_offset;

    voxel_addr_layout #(
        .X_BITS     (X_BITS),
        .Y_BITS     (Y_BITS),
        .Z_BITS     (Z_BITS),
        .BRICK_BITS (BRICK_BITS)
    ) u_layout (
        .i_mode   (r_s1_mode),
        .i_x      (r_s1_x),
        .i_y      (r_s1_y),
        .i_z      (r_s1_z),
        .o_offset (w_offset)
    );

    always_comb begin
        // A coordinate is in-grid only when every bit above the axis field,
        // sign bit included, is zero; that covers both < 0 and >= 2^BITS.
        w_in_oob  = (|bus.in_x[COORD_W-1:X_BITS]) |
                    (|bus.in_y[COORD_W-1:Y_BITS]) |
                    (|bus.in_z[COORD_W-1:Z_BITS]);

        w_s2_load = !r_s2_valid || bus.out_ready;
        w_s1_load = !r_s1_valid || w_s2_load;
        w_accept  = bus.in_valid && w_s1_load;
        // In drop mode an OOB entry leaves stage 1 as a bubble.
        w_s2_emit = r_s1_valid && !(DROP_OOB && r_s1_oob);

        w_s1_valid_nxt  = r_s1_valid;
        w_s1_oob_nxt    = r_s1_oob;
        w_s1_x_nxt      = r_s1_x;
        w_s1_y_nxt      = r_s1_y;
        w_s1_z_nxt      = r_s1_z;
        w_s1_mode_nxt   = r_s1_mode;
        w_s1_base_nxt   = r_s1_base;
        w_s1_tag_nxt    = r_s1_tag;
        w_s2_valid_nxt  = r_s2_valid;
        w_s2_oob_nxt    = r_s2_oob;
        w_s2_addr_nxt   = r_s2_addr;
        w_s2_tag_nxt    = r_s2_tag;
        w_oob_count_nxt = r_oob_count;

        if (w_s1_load) begin
            w_s1_valid_nxt = bus.in_valid;
            if (bus.in_valid) begin
                w_s1_oob_nxt  = w_in_oob;
                w_s1_x_nxt    = bus.in_x[X_BITS-1:0];
                w_s1_y_nxt    = bus.in_y[Y_BITS-1:0];
                w_s1_z_nxt    = bus.in_z[Z_BITS-1:0];
                w_s1_mode_nxt = addr_mode_e'(bus.cfg_mode);
                w_s1_base_nxt = bus.cfg_base;
                w_s1_tag_nxt  = bus.in_tag;
            end
        end

        // Output data only changes when a new result is loaded, so a held
        // result stays stable and a dropped request never reaches out_tag.
        if (w_s2_load) begin
            w_s2_valid_nxt = w_s2_emit;
            if (w_s2_emit) begin
                w_s2_oob_nxt  = r_s1_oob;
                w_s2_addr_nxt = r_s1_oob ? '0 : (r_s1_base + MEM_AW'(w_offset));
                w_s2_tag_nxt  = r_s1_tag;
            end
        end

        if (bus.oob_count_clr) begin
            w_oob_count_nxt = '0;
        end else if (w_accept && w_in_oob && !(&r_oob_count)) begin
            w_oob_count_nxt = r_oob_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_oob    <= 1'b0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_z      <= '0;
            r_s1_mode   <= ADDR_LINEAR;
            r_s1_base   <= '0;
            r_s1_tag    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_oob    <= 1'b0;
            r_s2_addr   <= '0;
            r_s2_tag    <= '0;
            r_oob_count <= '0;
        end else begin
            r_s1_valid  <= w_s1_valid_nxt;
            r_s1_oob    <= w_s1_oob_nxt;
            r_s1_x      <= w_s1_x_nxt;
            r_s1_y      <= w_s1_y_nxt;
            r_s1_z      <= w_s1_z_nxt;
            r_s1_mode   <= w_s1_mode_nxt;
            r_s1_base   <= w_s1_base_nxt;
            r_s1_tag    <= w_s1_tag_nxt;
            r_s2_valid  <= w_s2_valid_nxt;
            r_s2_oob    <= w_s2_oob_nxt;
            r_s2_addr   <= w_s2_addr_nxt;
            r_s2_tag    <= w_s2_tag_nxt;
            r_oob_count <= w_oob_count_nxt;
        end
    end

    assign bus.in_ready  = w_s1_load;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_addr  = r_s2_addr;
    assign bus.out_oob   = r_s2_oob;
    assign bus.out_tag   = r_s2_tag;
    assign bus.oob_count = r_oob_count;

endmodule : voxel_addr_gen
`default_nettype wire

// File: tb/tb_voxel_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voxel_addr_gen
//  Description : Self-checking bench for voxel_addr_gen. dut0 emits OOB
//                results, dut1 drops them and has a 3-bit OOB counter; dut1
//                sees exactly the requests dut0 accepts. Expected results come
//                from a grid-arithmetic reference model and per-DUT
//                scoreboards.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_voxel_addr_gen;
    import voxel_addr_gen_pkg::*;

    logic clk;
    logic rst_n;

    voxel_addr_gen_if #(.CNT_W(16)) bus0 ();
    voxel_addr_gen_if #(.CNT_W(3))  bus1 ();

    voxel_addr_gen #(.DROP_OOB(1'b0), .CNT_W(16)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    voxel_addr_gen #(.DROP_OOB(1'b1), .CNT_W(3)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    assign bus1.in_valid      = bus0.in_valid && bus0.in_ready;
    assign bus1.in_x          = bus0.in_x;
    assign bus1.in_y          = bus0.in_y;
    assign bus1.in_z          = bus0.in_z;
    assign bus1.in_tag        = bus0.in_tag;
    assign bus1.cfg_mode      = bus0.cfg_mode;
    assign bus1.cfg_base      = bus0.cfg_base;
    assign bus1.out_ready     = 1'b1;
    assign bus1.oob_count_clr = bus0.oob_count_clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_pop0   = 0;
    int          n_pop1   = 0;
    voxel_rsp_t  q0[$];
    voxel_rsp_t  q1[$];
    logic [15:0] cnt0;
    logic [2:0]  cnt1;
    logic [15:0] last_addr;
    logic        last_oob;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Reference: grid of 32x32x32, bricks of 4x4x4, 16-bit address space.
    function automatic voxel_rsp_t model(input int x, input int y, input int z,
                                         input logic [7:0] tag, input logic mode,
                                         input logic [15:0] base);
        voxel_rsp_t r;
        int off;
        r.tag = tag;
        r.oob = (x < 0 || x > 31 || y < 0 || y > 31 || z < 0 || z > 31);
        if (mode)
            off = (((z / 4) * 8 + y / 4) * 8 + x / 4) * 64 + (z % 4) * 16 + (y % 4) * 4 + x % 4;
        else
            off = x + 32 * y + 1024 * z;
        r.addr = r.oob ? 16'h0 : 16'((int'(base) + off) % 65536);
        return r;
    endfunction

    // Scoreboard fill and OOB counter model, evaluated mid-cycle on the
    // values that the next rising edge will act upon.
    always @(negedge clk) begin
        voxel_rsp_t r;
        logic       acc;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            cnt0 = '0;
            cnt1 = '0;
        end else begin
            acc = bus0.in_valid && bus0.in_ready;
            r = model(int'(bus0.in_x), int'(bus0.in_y), int'(bus0.in_z),
                      bus0.in_tag, bus0.cfg_mode, bus0.cfg_base);
            if (acc) begin
                q0.push_back(r);
                if (!r.oob) q1.push_back(r);
            end
            if (bus0.oob_count_clr) begin
                cnt0 = '0;
                cnt1 = '0;
            end else if (acc && r.oob) begin
                if (cnt0 != 16'hFFFF) cnt0 = cnt0 + 16'd1;
                if (cnt1 != 3'h7)     cnt1 = cnt1 + 3'd1;
            end
        end
    end

    // Output monitors: every valid cycle (held or consumed) must show the
    // oldest outstanding expected result.
    always @(negedge clk) begin
        if (rst_n && bus0.out_valid) begin
            if (q0.size() == 0) begin
                n_checks++;
                $error("FAIL out0_spurious: observed tag 0x%0h required no output", bus0.out_tag);
            end else begin
                chk("out0_addr", 64'(bus0.out_addr), 64'(q0[0].addr));
                chk("out0_oob",  64'(bus0.out_oob),  64'(q0[0].oob));
                chk("out0_tag",  64'(bus0.out_tag),  64'(q0[0].tag));
                if (bus0.out_ready) begin
                    last_addr = bus0.out_addr;
                    last_oob  = bus0.out_oob;
                    void'(q0.pop_front());
                    n_pop0++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus1.out_valid) begin
            if (q1.size() == 0) begin
                n_checks++;
                $error("FAIL out1_spurious: observed tag 0x%0h required no output", bus1.out_tag);
            end else begin
                chk("out1_addr", 64'(bus1.out_addr), 64'(q1[0].addr));
                chk("out1_tag",  64'(bus1.out_tag),  64'(q1[0].tag));
                void'(q1.pop_front());
                n_pop1++;
            end
        end
    end

    task automatic send(input int x, input int y, input int z, input logic [7:0] tag,
                        input logic mode, input logic [15:0] base);
        bit acc = 1'b0;
        bus0.in_x     = 7'(x);
        bus0.in_y     = 7'(y);
        bus0.in_z     = 7'(z);
        bus0.in_tag   = tag;
        bus0.cfg_mode = mode;
        bus0.cfg_base = base;
        bus0.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = bus0.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        bus0.in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $error("FAIL send_timeout: observed in_ready=0 for 50 cycles required acceptance (tag 0x%0h)", tag);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) break;
        end
        chk("drain", 64'(q0.size() + q1.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion required $finish within 200us");
        $fatal(1, "watchdog");
    end

    int t2_mode[4] = '{1, 1, 0, 0};
    int t2_x[4]    = '{5, 0, 5, 0};
    int t2_y[4]    = '{0, 4, 0, 4};
    int t2_exp[4]  = '{65, 512, 5, 128};

    initial begin
        int pop_before;
        int sent;
        bit have_req;
        bit acc;

        rst_n              = 1'b0;
        bus0.in_valid      = 1'b0;
        bus0.in_x          = '0;
        bus0.in_y          = '0;
        bus0.in_z          = '0;
        bus0.in_tag        = '0;
        bus0.cfg_mode      = 1'b0;
        bus0.cfg_base      = '0;
        bus0.out_ready     = 1'b1;
        bus0.oob_count_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(bus0.out_valid), 64'(0));
        chk("rst_out_addr",  64'(bus0.out_addr),  64'(0));
        chk("rst_out_oob",   64'(bus0.out_oob),   64'(0));
        chk("rst_out_tag",   64'(bus0.out_tag),   64'(0));
        chk("rst_oob_count", 64'(bus0.oob_count), 64'(0));
        chk("rst_in_ready",  64'(bus0.in_ready),  64'(1));
        @(posedge clk);
        #1;

        // Linear (3,2,1), two-cycle latency
        send(3, 2, 1, 8'h11, 1'b0, 16'h0000);
        @(negedge clk);
        chk("lat_cycle1_valid", 64'(bus0.out_valid), 64'(0));
        @(negedge clk);
        chk("lat_cycle2_valid", 64'(bus0.out_valid), 64'(1));
        chk("lin_321_addr",     64'(bus0.out_addr),  64'(16'h0443));
        chk("lin_321_oob",      64'(bus0.out_oob),   64'(0));
        @(posedge clk);
        #1;

        // Brick vs linear layout
        for (int i = 0; i < 4; i++) begin
            send(t2_x[i], t2_y[i], 0, 8'(8'h20 + i), t2_mode[i][0], 16'h0000);
            wait_drain();
            chk($sformatf("layout_%0d_addr", i), 64'(last_addr), 64'(t2_exp[i]));
        end

        // Base add wraps modulo 2^16
        send(1, 0, 0, 8'h30, 1'b0, 16'hFFFF);
        wait_drain();
        chk("wrap_addr", 64'(last_addr), 64'(0));

        // Random stream with 5 cycles of output backpressure
        pop_before = n_pop0;
        sent       = 0;
        have_req   = 1'b0;
        for (int c = 0; c < 80 && sent < 10; c++) begin
            bus0.out_ready = !(c >= 3 && c < 8);
            if (!have_req) begin
                bus0.in_x     = 7'(int'($urandom_range(39)) - 4);
                bus0.in_y     = 7'(int'($urandom_range(39)) - 4);
                bus0.in_z     = 7'(int'($urandom_range(39)) - 4);
                bus0.in_tag   = 8'(8'h40 + sent);
                bus0.cfg_mode = 1'($urandom_range(1));
                bus0.cfg_base = 16'($urandom);
                have_req      = 1'b1;
            end
            bus0.in_valid = 1'b1;
            @(negedge clk);
            if (c == 6) chk("stall_in_ready", 64'(bus0.in_ready), 64'(0));
            acc = bus0.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                have_req = 1'b0;
            end
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        chk("stream_sent", 64'(sent), 64'(10));
        wait_drain();
        chk("stream_emitted", 64'(n_pop0 - pop_before), 64'(10));

        // OOB handling: emitted (dut0) vs dropped (dut1)
        bus0.oob_count_clr = 1'b1;
        @(posedge clk);
        #1 bus0.oob_count_clr = 1'b0;
        pop_before = n_pop1;
        send(32, 0, 0, 8'hA1, 1'b0, 16'h0100);
        send(-1, 0, 0, 8'hA2, 1'b0, 16'h0100);
        wait_drain();
        chk("oob_last_oob",     64'(last_oob),             64'(1));
        chk("oob_last_addr",    64'(last_addr),            64'(0));
        chk("oob_count0",       64'(bus0.oob_count),       64'(2));
        chk("oob_count0_model", 64'(bus0.oob_count),       64'(cnt0));
        chk("oob_count1",       64'(bus1.oob_count),       64'(2));
        chk("drop_no_output",   64'(n_pop1 - pop_before),  64'(0));

        // Saturation of the 3-bit counter
        for (int i = 0; i < 6; i++) send(0, 40, 0, 8'(8'hB0 + i), 1'b1, 16'h0);
        wait_drain();
        chk("sat_count1",       64'(bus1.oob_count), 64'(3'h7));
        chk("sat_count1_model", 64'(bus1.oob_count), 64'(cnt1));
        chk("sat_count0",       64'(bus0.oob_count), 64'(8));

        // Clear wins over a same-cycle increment
        bus0.oob_count_clr = 1'b1;
        send(0, 0, -5, 8'hC0, 1'b0, 16'h0);
        bus0.oob_count_clr = 1'b0;
        wait_drain();
        chk("clr_count0", 64'(bus0.oob_count), 64'(0));
        chk("clr_count1", 64'(bus1.oob_count), 64'(0));

        // Reset with two requests in flight
        bus0.out_ready = 1'b0;
        send(1, 1, 1, 8'hD0, 1'b0, 16'h0);
        send(2, 2, 2, 8'hD1, 1'b0, 16'h0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid0", 64'(bus0.out_valid), 64'(0));
        chk("rst_mid_valid1", 64'(bus1.out_valid), 64'(0));
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_out", 64'(bus0.out_valid), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_voxel_addr_gen
`default_nettype wire
